// File: rtl/bus_arbiter_rr8_pkg.sv
// Shared constants, state encoding and helpers for the 8-master round-robin bus arbiter.
package bus_arbiter_rr8_pkg;

    localparam int NUM_REQ            = 8;
    localparam int SEL_WIDTH          = 3;
    localparam int DEFAULT_MAX_TENURE = 64;
    localparam int DEFAULT_CNT_WIDTH  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // One-hot grant vector for a binary master index.
    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_WIDTH-1:0] sel);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr8_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after the priority pointer, wrapping mod 8.
module rr_priority_pick
    import bus_arbiter_rr8_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] winner,
    output logic                 any_req
);

    logic [2*NUM_REQ-1:0] doubled_s;
    logic [NUM_REQ-1:0]   rotated_s;
    logic [SEL_WIDTH-1:0] offset_s;

    // Rotate so ptr sits at bit 0, find lowest set bit, then undo the rotation.
    always_comb begin
        doubled_s = {req, req};
        rotated_s = doubled_s[ptr +: NUM_REQ];
        offset_s  = {SEL_WIDTH{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            offset_s = rotated_s[i] ? SEL_WIDTH'(i) : offset_s;
        end
        winner  = ptr + offset_s;
        any_req = |req;
    end

endmodule

// File: rtl/bus_arbiter_rr8.sv
// Round-robin arbiter for the SDRAM-side bus: 8 masters, one tenure at a time, one turnaround cycle between tenures.
// Optional forced release after MAX_TENURE busy cycles is enabled with `define ARB_TENURE_TIMEOUT_EN.
module bus_arbiter_rr8
    import bus_arbiter_rr8_pkg::*;
#(
    parameter int MAX_TENURE = DEFAULT_MAX_TENURE,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
)
(
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [NUM_REQ-1:0]   Req,
    input  logic                 Done,
    output logic [NUM_REQ-1:0]   Grant,
    output logic [SEL_WIDTH-1:0] Sel,
    output logic                 GrantValid,
    output logic                 TimeoutErr
);

    arb_state_e           state_r, next_state_s;
    logic [SEL_WIDTH-1:0] ptr_r, next_ptr_s;
    logic [SEL_WIDTH-1:0] sel_r, next_sel_s;
    logic [NUM_REQ-1:0]   grant_r, next_grant_s;
    logic                 grant_valid_r, next_grant_valid_s;
    logic                 timeout_err_r, next_timeout_err_s;
    logic [SEL_WIDTH-1:0] winner_s;
    logic                 any_req_s;
    logic                 owner_req_s;
    logic                 forced_s;
    logic                 release_s;

    rr_priority_pick u_pick (
        .req     (Req),
        .ptr     (ptr_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    assign owner_req_s = Req[sel_r];

`ifdef ARB_TENURE_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] tenure_cnt_r;
    logic                 tenure_cap_s;

    assign tenure_cap_s = (tenure_cnt_r == CNT_WIDTH'(MAX_TENURE - 1));
    // Done or withdrawal in the cap cycle is a normal release, not a timeout.
    assign forced_s     = (state_r == ST_BUSY) && tenure_cap_s && !Done && owner_req_s;

    // Tenure counter: held at zero while unowned so every grant starts from zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tenure_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (state_r != ST_BUSY) begin
            tenure_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            tenure_cnt_r <= tenure_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end
`else
    assign forced_s = 1'b0;
`endif

    assign release_s = Done || !owner_req_s || forced_s;

    // Next-state and next-output logic; Sel only moves when a new tenure starts.
    always_comb begin
        next_state_s       = state_r;
        next_ptr_s         = ptr_r;
        next_sel_s         = sel_r;
        next_grant_s       = grant_r;
        next_grant_valid_s = grant_valid_r;
        next_timeout_err_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (any_req_s) begin
                    next_state_s       = ST_BUSY;
                    next_sel_s         = winner_s;
                    next_grant_s       = sel_to_onehot(winner_s);
                    next_grant_valid_s = 1'b1;
                end else begin
                    next_state_s       = ST_IDLE;
                    next_grant_s       = {NUM_REQ{1'b0}};
                    next_grant_valid_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (release_s) begin
                    next_state_s       = ST_GAP;
                    next_ptr_s         = sel_r + 3'd1;
                    next_grant_s       = {NUM_REQ{1'b0}};
                    next_grant_valid_s = 1'b0;
                    next_timeout_err_s = forced_s;
                end else begin
                    next_state_s       = ST_BUSY;
                end
            end
            default: begin
                next_state_s       = ST_IDLE;
                next_grant_s       = {NUM_REQ{1'b0}};
                next_grant_valid_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r       <= ST_IDLE;
            ptr_r         <= 3'd0;
            sel_r         <= 3'd0;
            grant_r       <= 8'h00;
            grant_valid_r <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            ptr_r         <= next_ptr_s;
            sel_r         <= next_sel_s;
            grant_r       <= next_grant_s;
            grant_valid_r <= next_grant_valid_s;
            timeout_err_r <= next_timeout_err_s;
        end
    end

    assign Grant      = grant_r;
    assign Sel        = sel_r;
    assign GrantValid = grant_valid_r;
    assign TimeoutErr = timeout_err_r;

endmodule

// File: tb/tb_bus_arbiter_rr8.sv
// Directed self-checking bench for bus_arbiter_rr8; timeout vectors run when ARB_TENURE_TIMEOUT_EN is defined.
module tb_bus_arbiter_rr8;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] Req;
    logic       Done;
    logic [7:0] Grant;
    logic [2:0] Sel;
    logic       GrantValid;
    logic       TimeoutErr;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    bus_arbiter_rr8 #(.MAX_TENURE(4), .CNT_WIDTH(3)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Req        (Req),
        .Done       (Done),
        .Grant      (Grant),
        .Sel        (Sel),
        .GrantValid (GrantValid),
        .TimeoutErr (TimeoutErr)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] s, input logic te);
        check_eq({tag, ".grant"}, 32'(Grant), 32'(g));
        check_eq({tag, ".sel"}, 32'(Sel), 32'(s));
        check_eq({tag, ".valid"}, 32'(GrantValid), 32'(|g));
        check_eq({tag, ".tmo"}, 32'(TimeoutErr), 32'(te));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        Req     = 8'h00;
        Done    = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] exp_g;
        Reset_n = 1'b0;
        Req     = 8'h00;
        Done    = 1'b0;
        repeat (2) tick();
        check_out("rst", 8'h00, 3'd0, 1'b0);
        Reset_n = 1'b1;
        tick();
        check_out("idle", 8'h00, 3'd0, 1'b0);

        // Single request, Done release, pointer moves to 3.
        Req = 8'h04; tick(); check_out("t1.grant", 8'h04, 3'd2, 1'b0);
        Done = 1'b1; tick(); check_out("t1.rel", 8'h00, 3'd2, 1'b0);
        Done = 1'b0; Req = 8'h00;
        tick(); check_out("t1.gap", 8'h00, 3'd2, 1'b0);
        Req = 8'h05; tick(); check_out("t1.ptr3", 8'h01, 3'd0, 1'b0);
        Req = 8'h00; tick(); check_out("t1.drop", 8'h00, 3'd0, 1'b0);
        tick();

        // All requesting: order 0..7 then wrap to 0, one dead cycle each.
        do_reset();
        Req = 8'hFF; tick();
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            check_out("rr.own", exp_g, 3'(k % 8), 1'b0);
            tick(); check_out("rr.hold", exp_g, 3'(k % 8), 1'b0);
            Done = 1'b1; tick(); check_out("rr.gap", 8'h00, 3'(k % 8), 1'b0);
            Done = 1'b0; tick();
        end
        check_out("rr.next", 8'h02, 3'd1, 1'b0);
        Req = 8'h00; tick(); check_out("rr.end", 8'h00, 3'd1, 1'b0);
        tick();

        // Owner 5; 6 and 1 arrive mid-tenure; 6 wins first, then 1 after 6 withdraws.
        do_reset();
        Req = 8'h20; tick(); check_out("t3.own5", 8'h20, 3'd5, 1'b0);
        Req = 8'h62; tick(); check_out("t3.ignore", 8'h20, 3'd5, 1'b0);
        tick(); check_out("t3.ignore2", 8'h20, 3'd5, 1'b0);
        Done = 1'b1; tick(); check_out("t3.rel", 8'h00, 3'd5, 1'b0);
        Done = 1'b0; Req = 8'h42; tick(); check_out("t3.own6", 8'h40, 3'd6, 1'b0);
        Req = 8'h02; tick(); check_out("t3.wd6", 8'h00, 3'd6, 1'b0);
        tick(); check_out("t3.own1", 8'h02, 3'd1, 1'b0);
        Req = 8'h00; tick(); check_out("t3.wd1", 8'h00, 3'd1, 1'b0);
        tick(); check_out("t3.idle", 8'h00, 3'd1, 1'b0);

        // Owner 3 withdraws without Done; stray Done in IDLE is ignored.
        Req = 8'h08; tick(); check_out("t4.own3", 8'h08, 3'd3, 1'b0);
        tick(); check_out("t4.hold", 8'h08, 3'd3, 1'b0);
        Req = 8'h00; tick(); check_out("t4.wd", 8'h00, 3'd3, 1'b0);
        tick();
        Done = 1'b1; tick(); check_out("t4.idledone", 8'h00, 3'd3, 1'b0);
        Done = 1'b0; tick(); check_out("t4.idle", 8'h00, 3'd3, 1'b0);
        Req = 8'h09; tick(); check_out("t4.ptr4", 8'h01, 3'd0, 1'b0);
        Done = 1'b1; tick(); check_out("t4.rel", 8'h00, 3'd0, 1'b0);
        Done = 1'b0; Req = 8'h00; tick(); tick();

        // Asynchronous reset mid-tenure, then pointer is back at 0.
        Req = 8'h10; tick(); check_out("t5.own4", 8'h10, 3'd4, 1'b0);
        #2 Reset_n = 1'b0;
        #1 check_out("t5.async", 8'h00, 3'd0, 1'b0);
        Req = 8'h80;
        tick(); check_out("t5.inrst", 8'h00, 3'd0, 1'b0);
        Reset_n = 1'b1;
        tick(); check_out("t5.own7", 8'h80, 3'd7, 1'b0);
        Req = 8'h81; Done = 1'b1; tick(); check_out("t5.rel", 8'h00, 3'd7, 1'b0);
        Done = 1'b0; tick(); check_out("t5.wrap0", 8'h01, 3'd0, 1'b0);
        Req = 8'h00; tick(); tick();

`ifdef ARB_TENURE_TIMEOUT_EN
        // Forced release after 4 busy cycles; Done in the 4th cycle suppresses the error.
        do_reset();
        Req = 8'h01; tick(); check_out("tmo.grant", 8'h01, 3'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick(); check_out("tmo.busy", 8'h01, 3'd0, 1'b0);
        end
        tick(); check_out("tmo.forced", 8'h00, 3'd0, 1'b1);
        tick(); check_out("tmo.regrant", 8'h01, 3'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick(); check_out("tmo.busy2", 8'h01, 3'd0, 1'b0);
        end
        Done = 1'b1; tick(); check_out("tmo.done4", 8'h00, 3'd0, 1'b0);
        Done = 1'b0; Req = 8'h00; tick(); check_out("tmo.gap", 8'h00, 3'd0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
